lcg_step_ctrl: RTL and testbench

//  Linear congruential PRNG sequencer: x[n+1] = (A*x[n] + C) mod 2^WIDTH.

---
 rtl/prng_pkg.sv | 17 +
 rtl/lcg_step_ctrl_if.sv | 30 +++
 rtl/lcg_step_ctrl.sv | 91 +++++++++
 tb/tb_lcg_step_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared definitions for the LCG step sequencer: FSM encoding and default
// generator constants (Numerical Recipes LCG).
package prng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_HOLD = 2'd3
    } lcg_state_e;

    localparam int unsigned LCG_WIDTH     = 32;
    localparam logic [31:0] LCG_MULT_A    = 32'd1664525;
    localparam logic [31:0] LCG_INC_C     = 32'd1013904223;
    localparam logic [31:0] LCG_SEED_INIT = 32'd1;

endpackage

// File: rtl/lcg_step_ctrl_if.sv
// Bundle of the sequencer's control, multiplier-side and output-side signals.
// master = the sequencer, slave = its surroundings (mult block and consumer).
interface lcg_step_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic                 run;
    logic                 seed_load;
    logic [WIDTH-1:0]     seed_data;
    logic [WIDTH-1:0]     mul_multiplicand;
    logic [WIDTH-1:0]     mul_multiplier;
    logic                 mul_enable;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_result;
    logic [WIDTH-1:0]     rand_data;
    logic                 rand_valid;
    logic                 rand_ready;
    logic [31:0]          gen_count;

    modport master (
        input  run, seed_load, seed_data, mul_done, mul_result, rand_ready,
        output mul_multiplicand, mul_multiplier, mul_enable,
               rand_data, rand_valid, gen_count
    );

    modport slave (
        output run, seed_load, seed_data, mul_done, mul_result, rand_ready,
        input  mul_multiplicand, mul_multiplier, mul_enable,
               rand_data, rand_valid, gen_count
    );
endinterface

// File: rtl/lcg_step_ctrl.sv
// LCG sequencer x[n+1] = (A*x[n] + C) mod 2^WIDTH around an external multi-cycle
// multiplier; results leave on a valid/ready port, seed_load aborts and reseeds.
module lcg_step_ctrl
    import prng_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] MULT_A    = WIDTH'(LCG_MULT_A),
    parameter logic [WIDTH-1:0] INC_C     = WIDTH'(LCG_INC_C),
    parameter logic [WIDTH-1:0] SEED_INIT = WIDTH'(LCG_SEED_INIT)
) (
    input logic           clk,
    input logic           rst,
    lcg_step_ctrl_if.master bus
);

    lcg_state_e        fsm_r;
    logic [WIDTH-1:0]  state_r;
    logic [WIDTH-1:0]  prod_lo_r;
    logic [WIDTH-1:0]  multiplicand_r;
    logic              mul_enable_r;
    logic [WIDTH-1:0]  rand_data_r;
    logic              rand_valid_r;
    logic [31:0]       gen_count_r;
    logic [WIDTH-1:0]  sum_s;

    // Increment stage; the carry out of the top bit is intentionally dropped.
    assign sum_s = prod_lo_r + INC_C;

    // Sequencer FSM and all datapath registers; seed_load overrides every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r          <= ST_IDLE;
            state_r        <= SEED_INIT;
            prod_lo_r      <= {WIDTH{1'b0}};
            multiplicand_r <= SEED_INIT;
            mul_enable_r   <= 1'b0;
            rand_data_r    <= {WIDTH{1'b0}};
            rand_valid_r   <= 1'b0;
            gen_count_r    <= 32'd0;
        end else if (bus.seed_load) begin
            state_r      <= bus.seed_data;
            mul_enable_r <= 1'b0;
            rand_valid_r <= 1'b0;
            fsm_r        <= ST_IDLE;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    // A done left high by the previous operation must clear first.
                    if (bus.run && !bus.mul_done) begin
                        multiplicand_r <= state_r;
                        mul_enable_r   <= 1'b1;
                        fsm_r          <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (bus.mul_done) begin
                        prod_lo_r    <= WIDTH'(bus.mul_result);
                        mul_enable_r <= 1'b0;
                        fsm_r        <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    state_r      <= sum_s;
                    rand_data_r  <= sum_s;
                    rand_valid_r <= 1'b1;
                    fsm_r        <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.rand_ready) begin
                        rand_valid_r <= 1'b0;
                        gen_count_r  <= gen_count_r + 32'd1;
                        fsm_r        <= ST_IDLE;
                    end
                end
                default: begin
                    mul_enable_r <= 1'b0;
                    rand_valid_r <= 1'b0;
                    fsm_r        <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mul_multiplicand = multiplicand_r;
    assign bus.mul_multiplier   = MULT_A;
    assign bus.mul_enable       = mul_enable_r;
    assign bus.rand_data        = rand_data_r;
    assign bus.rand_valid       = rand_valid_r;
    assign bus.gen_count        = gen_count_r;

endmodule

// File: tb/tb_lcg_step_ctrl.sv
// Randomised bench for lcg_step_ctrl: behavioural variable-latency multiplier,
// arithmetic LCG reference model and handshake scoreboard.
module tb_lcg_step_ctrl;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcg_step_ctrl_if #(.WIDTH(W)) bus ();

    lcg_step_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_x;
    logic [31:0] exp_cnt;
    logic [31:0] acc_q[$];
    logic        prev_hold;
    logic [31:0] prev_data;

    function automatic logic [31:0] lcg_next(input logic [31:0] x);
        longint unsigned t;
        t = 64'd1664525 * longint'(x) + 64'd1013904223;
        return t[31:0];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural multiplier: captures operands when enable rises, random latency.
    int unsigned m_cnt;
    logic        m_busy;
    logic [31:0] m_a, m_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy         <= 1'b0;
            m_cnt          <= 0;
            bus.mul_done   <= 1'b0;
            bus.mul_result <= 64'd0;
        end else if (!bus.mul_enable) begin
            m_busy       <= 1'b0;
            bus.mul_done <= 1'b0;
        end else if (!m_busy) begin
            m_busy       <= 1'b1;
            m_cnt        <= $urandom_range(34, 3);
            m_a          <= bus.mul_multiplicand;
            m_b          <= bus.mul_multiplier;
            bus.mul_done <= 1'b0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else begin
            bus.mul_done   <= 1'b1;
            bus.mul_result <= {32'd0, m_a} * {32'd0, m_b};
        end
    end

    // Scoreboard: checks every accepted value and output stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_eq("hold_valid", bus.rand_valid, 1);
                check_eq("hold_data", bus.rand_data, prev_data);
            end
            if (bus.rand_valid && bus.rand_ready && !bus.seed_load) begin
                check_eq("data", bus.rand_data, lcg_next(model_x));
                check_eq("gen_count", bus.gen_count, exp_cnt);
                model_x = lcg_next(model_x);
                exp_cnt = exp_cnt + 32'd1;
                acc_q.push_back(bus.rand_data);
            end
            prev_hold = bus.rand_valid && !bus.rand_ready && !bus.seed_load;
            prev_data = bus.rand_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.run        = 1'b0;
        bus.seed_load  = 1'b0;
        bus.seed_data  = 32'd0;
        bus.rand_ready = 1'b0;
        model_x        = 32'd1;
        exp_cnt        = 32'd0;
        acc_q.delete();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic seed(input logic [31:0] s);
        bus.seed_data = s;
        bus.seed_load = 1'b1;
        model_x       = s;
        tick(1);
        bus.seed_load = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        if (k >= budget) check_eq("acc_wait", acc_q.size(), n);
    endtask

    task automatic wait_enable(input int budget);
        int k = 0;
        while (!bus.mul_enable && k < budget) begin
            tick(1);
            k++;
        end
        if (k >= budget) check_eq("enable_wait", bus.mul_enable, 1);
    endtask

    task automatic go_idle();
        bus.run        = 1'b0;
        bus.rand_ready = 1'b1;
        tick(60);
        acc_q.delete();
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] g;
        int          k;
        int          en_seen;

        // Reset values
        do_reset();
        check_eq("rst_valid", bus.rand_valid, 0);
        check_eq("rst_data", bus.rand_data, 0);
        check_eq("rst_enable", bus.mul_enable, 0);
        check_eq("rst_count", bus.gen_count, 0);
        check_eq("rst_mcand", bus.mul_multiplicand, 1);
        check_eq("rst_mplier", bus.mul_multiplier, 1664525);

        // Default seed 1
        bus.rand_ready = 1'b1;
        bus.run        = 1'b1;
        wait_acc(1, 200);
        check_eq("seed1_first", acc_q[0], 32'd1015568748);
        go_idle();

        // Seed 0 sequence
        do_reset();
        seed(32'd0);
        bus.rand_ready = 1'b1;
        bus.run        = 1'b1;
        wait_acc(3, 400);
        bus.run = 1'b0;
        check_eq("seq0_v0", acc_q[0], 32'd1013904223);
        check_eq("seq0_v1", acc_q[1], 32'd1196435762);
        check_eq("seq0_v2", acc_q[2], 32'd3519870697);
        check_eq("seq0_count", bus.gen_count, 3);
        go_idle();

        // All-ones seed: wrap/truncation
        seed(32'hFFFF_FFFF);
        bus.run = 1'b1;
        wait_acc(1, 200);
        check_eq("wrap_val", acc_q[0], 32'd1012239698);
        go_idle();

        // Back-pressure for 20 cycles
        bus.rand_ready = 1'b0;
        bus.run        = 1'b1;
        k = 0;
        while (!bus.rand_valid && k < 200) begin
            tick(1);
            k++;
        end
        if (k >= 200) check_eq("valid_wait", bus.rand_valid, 1);
        d       = bus.rand_data;
        en_seen = 0;
        repeat (20) begin
            tick(1);
            if (bus.mul_enable) en_seen++;
        end
        check_eq("stall_no_enable", en_seen, 0);
        check_eq("stall_data", bus.rand_data, d);
        g              = exp_cnt;
        bus.run        = 1'b0;
        bus.rand_ready = 1'b1;
        tick(2);
        check_eq("stall_count", bus.gen_count, g + 32'd1);
        check_eq("stall_valid_low", bus.rand_valid, 0);
        go_idle();

        // Seed load aborts an in-flight multiply
        bus.run = 1'b1;
        wait_enable(20);
        tick(2);
        seed(32'd0);
        check_eq("abort_enable", bus.mul_enable, 0);
        check_eq("abort_valid", bus.rand_valid, 0);
        wait_acc(1, 200);
        check_eq("abort_next", acc_q[0], 32'd1013904223);
        go_idle();

        // run dropped mid-multiply: step completes, nothing new starts
        bus.run = 1'b1;
        wait_enable(20);
        bus.run = 1'b0;
        wait_acc(1, 200);
        en_seen = 0;
        repeat (60) begin
            tick(1);
            if (bus.mul_enable) en_seen++;
        end
        check_eq("stop_no_enable", en_seen, 0);
        check_eq("stop_count", acc_q.size(), 1);

        // Async reset while in ADD
        bus.run = 1'b1;
        k = 0;
        while (!(bus.mul_enable && bus.mul_done) && k < 200) begin
            tick(1);
            k++;
        end
        if (k >= 200) check_eq("done_wait", bus.mul_done, 1);
        tick(1);
        bus.run = 1'b0;
        #2;
        rst     = 1'b1;
        model_x = 32'd1;
        exp_cnt = 32'd0;
        #1;
        check_eq("arst_valid", bus.rand_valid, 0);
        check_eq("arst_data", bus.rand_data, 0);
        check_eq("arst_enable", bus.mul_enable, 0);
        check_eq("arst_count", bus.gen_count, 0);
        check_eq("arst_mcand", bus.mul_multiplicand, 1);
        tick(2);
        rst = 1'b0;
        acc_q.delete();

        // Randomised run/ready/seed traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            bus.run        = ($urandom_range(3, 0) != 0);
            bus.rand_ready = $urandom_range(1, 0);
            if ($urandom_range(59, 0) == 0) begin
                bus.seed_data = $urandom;
                bus.seed_load = 1'b1;
                model_x       = bus.seed_data;
            end else begin
                bus.seed_load = 1'b0;
            end
            tick(1);
        end
        bus.seed_load = 1'b0;
        go_idle();
        check_eq("final_count", bus.gen_count, exp_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
